// File: rtl/vga_pkg.sv
// Shared 640x480 timing constants, frame geometry and raster FSM encoding.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam bit VGA_SYNC_POL = 1'b0;
    localparam int VGA_ADDR_W   = 19;

    localparam int VGA_H_TOTAL   = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL   = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_FB_PIXELS = VGA_H_ACTIVE * VGA_V_ACTIVE;

    // Raster FSM: IDLE holds counters at 0, DRAIN finishes the current frame.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } vga_state_e;

    // Counter width able to hold 0..total-1.
    function automatic int vga_cnt_w(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_raster_cnt.sv
// Horizontal/vertical raster counters with sync decode and active-video flag.
// Counters sit at (0,0) while run is low and free-run across frames otherwise.
module vga_raster_cnt
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = VGA_SYNC_POL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic frame_end,
    output logic active,
    output logic hsync,
    output logic vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = vga_cnt_w(H_TOTAL);
    localparam int VC_W    = vga_cnt_w(V_TOTAL);

    localparam logic [HC_W-1:0] HC_LAST   = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0] VC_LAST   = VC_W'(V_TOTAL - 1);
    localparam logic [HC_W-1:0] HC_ACT    = HC_W'(H_ACTIVE);
    localparam logic [VC_W-1:0] VC_ACT    = VC_W'(V_ACTIVE);
    localparam logic [HC_W-1:0] HS_BEGIN  = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_END    = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VC_W-1:0] VS_BEGIN  = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_END    = VC_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [HC_W-1:0] hc;
    logic [VC_W-1:0] vc;
    logic            line_end;

    assign line_end  = (hc == HC_LAST);
    assign frame_end = line_end && (vc == VC_LAST);

    // Pixel/line counters; cleared whenever the raster is stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc <= '0;
            vc <= '0;
        end else if (!run) begin
            hc <= '0;
            vc <= '0;
        end else if (line_end) begin
            hc <= '0;
            vc <= (vc == VC_LAST) ? '0 : vc + VC_W'(1);
        end else begin
            hc <= hc + HC_W'(1);
        end
    end

    // Visible region and sync windows; syncs stay deasserted while stopped.
    always_comb begin
        active = run && (hc < HC_ACT) && (vc < VC_ACT);
        hsync  = (run && (hc >= HS_BEGIN) && (hc < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync  = (run && (vc >= VS_BEGIN) && (vc < VS_END)) ? SYNC_POL : ~SYNC_POL;
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port owner: scan-out reads own the RAM during active video,
// the drawing writer gets it in blanking and whenever the raster is idle.
// Sync and colour leave two clocks after the counter position that made them.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = VGA_SYNC_POL,
    parameter int ADDR_W   = VGA_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_wr_valid,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [2:0]        i_wr_data,
    output logic              o_wr_ready,
    output logic              o_wr_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [2:0]        o_mem_wdata,
    input  logic [2:0]        i_mem_rdata,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_red,
    output logic              o_grn,
    output logic              o_blu,
    output logic              o_frame_start
);

    localparam int STAGES    = 2;
    localparam int FB_PIXELS = H_ACTIVE * V_ACTIVE;

    localparam logic [ADDR_W:0] FB_LIMIT = (ADDR_W + 1)'(FB_PIXELS);

    vga_state_e        state;
    logic              run;
    logic              frame_end;
    logic              active;
    logic              hs_raw;
    logic              vs_raw;
    logic              arb_en;
    logic              wr_xfer;
    logic              wr_oob;
    logic [ADDR_W-1:0] rd_addr;
    logic [STAGES-1:0] vld_pipe;
    logic [STAGES-1:0] hs_pipe;
    logic [STAGES-1:0] vs_pipe;
    logic [2:0]        pix_q;

    assign run = (state != ST_IDLE);

    vga_raster_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_raster (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .run       (run),
        .frame_end (frame_end),
        .active    (active),
        .hsync     (hs_raw),
        .vsync     (vs_raw)
    );

    // Raster FSM; frame_start marks the first cycle at (0,0) of a running frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            o_frame_start <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_frame_start <= i_enable;
                    if (i_enable) state <= ST_RUN;
                end
                ST_RUN: begin
                    o_frame_start <= frame_end && i_enable;
                    if (!i_enable) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    o_frame_start <= frame_end && i_enable;
                    if (i_enable)       state <= ST_RUN;
                    else if (frame_end) state <= ST_IDLE;
                end
                default: begin
                    o_frame_start <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

    // Grant is held off for the first cycle out of reset so a writer that
    // was mid-request when reset hit cannot strobe the RAM on release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) arb_en <= 1'b0;
        else          arb_en <= 1'b1;
    end

    assign o_wr_ready = arb_en && !active;
    assign wr_xfer    = i_wr_valid && o_wr_ready;
    assign wr_oob     = ({1'b0, i_wr_addr} >= FB_LIMIT);

    // Linear scan-out address: one step per visible pixel, so no y*width multiply.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                rd_addr <= '0;
        else if (!run || frame_end)  rd_addr <= '0;
        else if (active)             rd_addr <= rd_addr + ADDR_W'(1);
    end

    // RAM port mux: reads win during active video, otherwise an accepted write.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        if (active) begin
            o_mem_addr = rd_addr;
        end else if (wr_xfer) begin
            o_mem_addr  = i_wr_addr;
            o_mem_wdata = i_wr_data;
            o_mem_we    = !wr_oob;
        end
    end

    // Out-of-range writes are swallowed and flagged one cycle later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_wr_err <= 1'b0;
        else          o_wr_err <= wr_xfer && wr_oob;
    end

    // Two-stage video pipe: RAM latency plus the colour register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe <= '0;
            hs_pipe  <= {STAGES{~SYNC_POL}};
            vs_pipe  <= {STAGES{~SYNC_POL}};
            pix_q    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-2:0], active};
            hs_pipe  <= {hs_pipe[STAGES-2:0], hs_raw};
            vs_pipe  <= {vs_pipe[STAGES-2:0], vs_raw};
            pix_q    <= i_mem_rdata;
        end
    end

    assign o_hsync = hs_pipe[STAGES-1];
    assign o_vsync = vs_pipe[STAGES-1];
    assign o_red   = pix_q[2] & vld_pipe[STAGES-1];
    assign o_grn   = pix_q[1] & vld_pipe[STAGES-1];
    assign o_blu   = pix_q[0] & vld_pipe[STAGES-1];

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter on a shrunken 16x8 raster (8x4 visible) so whole
// frames fit in a few hundred clocks. Hand-picked vectors plus a per-cycle
// reference of raster position, 2-clock output delay and writer handshake.
module tb_vga_fb_arbiter;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = 16, VT = 8, NPIX = 32, AW = 19;

    logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0, wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [2:0]    wr_data = '0;
    logic          wr_ready, wr_err, mem_we, hsync, vsync, red, grn, blu, frame_start;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_wdata;
    bit   [2:0]    mem_rdata;

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .ADDR_W(AW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
        .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_wr_ready(wr_ready), .o_wr_err(wr_err),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata),
        .o_hsync(hsync), .o_vsync(vsync),
        .o_red(red), .o_grn(grn), .o_blu(blu),
        .o_frame_start(frame_start)
    );

    // RAM: unwritten locations read back as addr[2:0] (the preload pattern).
    bit [2:0] ram     [0:1023];
    bit       ram_set [0:1023];
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr[9:0]]     <= mem_wdata;
            ram_set[mem_addr[9:0]] <= 1'b1;
        end
        mem_rdata <= ram_set[mem_addr[9:0]] ? ram[mem_addr[9:0]] : mem_addr[2:0];
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference state: 0 idle, 1 run, 2 drain.
    int       m_st, m_hc, m_vc;
    bit       m_fs, m_arb, m_err;
    bit       p_hs [3], p_vs [3], p_act [3];
    bit [2:0] p_pix [3];
    bit [2:0] exp_mem [0:NPIX-1];

    function automatic bit cur_act();
        return (m_st != 0) && (m_hc < HA) && (m_vc < VA);
    endfunction

    task automatic model_reset();
        m_st = 0; m_hc = 0; m_vc = 0; m_fs = 0; m_arb = 0; m_err = 0;
        for (int i = 0; i < 3; i++) begin
            p_hs[i] = 1; p_vs[i] = 1; p_act[i] = 0; p_pix[i] = 0;
        end
    endtask

    task automatic model_adv(input bit en, input bit xv, input logic [AW-1:0] xa, input logic [2:0] xd);
        bit rdy, xfer, wrap;
        int nxt;
        rdy  = m_arb && !cur_act();
        xfer = xv && rdy;
        wrap = (m_hc == HT-1) && (m_vc == VT-1);
        m_err = xfer && (xa >= NPIX);
        if (xfer && xa < NPIX) exp_mem[xa[4:0]] = xd;
        m_arb = 1;
        if (m_st == 0) begin
            m_fs = en;
            m_st = en ? 1 : 0;
            m_hc = 0; m_vc = 0;
        end else begin
            nxt  = en ? 1 : ((m_st == 2 && wrap) ? 0 : 2);
            m_fs = wrap && (nxt == 1);
            if (nxt == 0) begin
                m_hc = 0; m_vc = 0;
            end else if (m_hc == HT-1) begin
                m_hc = 0;
                m_vc = (m_vc == VT-1) ? 0 : m_vc + 1;
            end else begin
                m_hc = m_hc + 1;
            end
            m_st = nxt;
        end
        for (int i = 2; i > 0; i--) begin
            p_hs[i] = p_hs[i-1]; p_vs[i] = p_vs[i-1]; p_act[i] = p_act[i-1]; p_pix[i] = p_pix[i-1];
        end
        p_act[0] = cur_act();
        p_hs[0]  = !((m_st != 0) && m_hc >= HA+HF && m_hc < HA+HF+HS);
        p_vs[0]  = !((m_st != 0) && m_vc >= VA+VF && m_vc < VA+VF+VS);
        p_pix[0] = p_act[0] ? exp_mem[m_vc*HA + m_hc] : 3'b000;
    endtask

    // Advance one clock: DUT and reference both consume this cycle's inputs.
    task automatic step();
        bit            en = enable, xv = wr_valid;
        logic [AW-1:0] xa = wr_addr;
        logic [2:0]    xd = wr_data;
        @(posedge clk); #1;
        model_adv(en, xv, xa, xd);
    endtask

    task automatic check_cycle();
        bit            act, rdy, xf, ew;
        logic [AW-1:0] ea;
        logic [2:0]    ed;
        act = cur_act();
        rdy = m_arb && !act;
        xf  = wr_valid && rdy;
        ew  = xf && (wr_addr < NPIX);
        ea  = act ? AW'(m_vc*HA + m_hc) : (xf ? wr_addr : '0);
        ed  = xf ? wr_data : 3'b000;
        chk("pins", {26'd0, hsync, vsync, red, grn, blu, frame_start},
                    {26'd0, p_hs[2], p_vs[2], p_pix[2], m_fs});
        chk("bus",  {7'd0, wr_ready, mem_we, wr_err, mem_wdata, mem_addr},
                    {7'd0, rdy, ew, m_err, ed, ea});
    endtask

    task automatic drive(input int k);
        case (k)
            19:  begin wr_valid = 1; wr_addr = AW'(13); wr_data = 3'b010; end
            25:  wr_valid = 0;
            40:  begin wr_valid = 1; wr_addr = AW'(32); wr_data = 3'b111; end
            41:  wr_valid = 0;
            56:  begin wr_valid = 1; wr_addr = AW'(31); wr_data = 3'b000; end
            57:  wr_valid = 0;
            160: enable = 0;
            200: enable = 1;
            272: enable = 0;
            388: begin wr_valid = 1; wr_addr = AW'(2); wr_data = 3'b110; end
            391: wr_valid = 0;
            396: enable = 1;
            438: begin wr_valid = 1; wr_addr = AW'(5); wr_data = 3'b111; end
            default: ;
        endcase
    endtask

    // Hand-derived spot checks at known raster positions.
    task automatic hand(input int k);
        case (k)
            0:   begin chk("fs_first", frame_start, 1); chk("rd_addr0", mem_addr, 0); chk("ready_act", wr_ready, 0); end
            1:   begin chk("fs_once", frame_start, 0); chk("rd_addr1", mem_addr, 1); end
            3:   chk("pix1", {red, grn, blu}, 3'b001);
            9:   chk("pix7", {red, grn, blu}, 3'b111);
            10:  chk("blank_rgb", {red, grn, blu}, 3'b000);
            11:  chk("hs_before", hsync, 1);
            12:  chk("hs_start", hsync, 0);
            14:  chk("hs_last", hsync, 0);
            15:  chk("hs_end", hsync, 1);
            23:  begin chk("wr_wait_rdy", wr_ready, 0); chk("wr_wait_we", mem_we, 0); end
            24:  begin chk("wr_xfer_we", mem_we, 1); chk("wr_xfer_addr", mem_addr, 13); chk("wr_xfer_data", mem_wdata, 3'b010); end
            40:  begin chk("oob_rdy", wr_ready, 1); chk("oob_we", mem_we, 0); chk("oob_err_pre", wr_err, 0); end
            41:  chk("oob_err", wr_err, 1);
            42:  chk("oob_err_once", wr_err, 0);
            56:  begin chk("edge_we", mem_we, 1); chk("edge_addr", mem_addr, 31); end
            57:  chk("edge_err", wr_err, 0);
            81:  chk("vs_before", vsync, 1);
            82:  chk("vs_start", vsync, 0);
            113: chk("vs_last", vsync, 0);
            114: chk("vs_end", vsync, 1);
            151: chk("readback13", {red, grn, blu}, 3'b010);
            185: chk("readback31", {red, grn, blu}, 3'b000);
            256: chk("fs_after_drain", frame_start, 1);
            386: begin chk("idle_hs", hsync, 1); chk("idle_vs", vsync, 1); chk("idle_rdy", wr_ready, 1); end
            388: begin chk("idle_we", mem_we, 1); chk("idle_addr", mem_addr, 2); end
            401: chk("readback2", {red, grn, blu}, 3'b110);
            438: chk("inflight_we", mem_we, 1);
            default: ;
        endcase
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) exp_mem[i] = i[2:0];
        model_reset();

        #12;
        chk("rst_ready", wr_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_sync", {hsync, vsync}, 2'b11);
        chk("rst_rgb", {red, grn, blu}, 3'b000);
        chk("rst_fs", frame_start, 0);
        chk("rst_addr", mem_addr, 0);

        @(negedge clk); rst_n = 1;
        step(); #1; check_cycle();
        chk("idle_ready0", wr_ready, 1);

        enable = 1;
        for (int k = 0; k <= 438; k++) begin
            step();
            drive(k);
            #1;
            check_cycle();
            hand(k);
        end

        // Reset lands mid-cycle while a write is being granted.
        #1 rst_n = 0;
        #1;
        chk("arst_ready", wr_ready, 0);
        chk("arst_we", mem_we, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_wdata", mem_wdata, 0);
        chk("arst_err", wr_err, 0);
        chk("arst_sync", {hsync, vsync}, 2'b11);
        chk("arst_rgb", {red, grn, blu}, 3'b000);
        chk("arst_fs", frame_start, 0);
        wr_valid = 0;
        enable   = 0;
        model_reset();
        @(negedge clk); rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            step(); #1;
            check_cycle();
        end
        chk("post_rst_we", mem_we, 0);
        chk("post_rst_rdy", wr_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
